// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared constants for the memory-mapped IO block:
//   - one-hot select-bit positions inside the word address
//   - UART_CTRL write-command and status-readback bit positions
//   - UART serializer state encoding
// -----------------------------------------------------------------------------
package io_pkg;

    // Byte address -> word address offset.
    localparam int WORD_ADDR_LSB = 2;

    // One-hot select bits within the word address.
    localparam int IO_LEDS_BIT      = 0;
    localparam int IO_UART_DAT_BIT  = 1;
    localparam int IO_UART_CTRL_BIT = 2;

    // UART_CTRL write command bits.
    localparam int CTRL_CLR_OVF_BIT = 3;
    localparam int CTRL_IRQ_EN_BIT  = 8;

    // UART_CTRL status readback bits.
    localparam int ST_FULL_BIT   = 0;
    localparam int ST_EMPTY_BIT  = 1;
    localparam int ST_ACTIVE_BIT = 2;
    localparam int ST_OVF_BIT    = 3;
    localparam int ST_IRQ_EN_BIT = 8;
    localparam int ST_BUSY_BIT   = 9;
    localparam int ST_LEVEL_LSB  = 16;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/io_uart_tx.sv
// -----------------------------------------------------------------------------
// io_uart_tx
// 8N1 UART serializer with its own baud counter. Accepts one byte per
// valid/ready handshake while idle; txd_o is registered, so the start bit
// appears on the line one clock after the byte is accepted.
// Ports:
//   clk_i    in   system clock
//   reset_i  in   synchronous, active-high reset
//   valid_i  in   byte available
//   data_i   in   byte to send
//   ready_o  out  serializer idle (handshake completes when valid_i & ready_o)
//   txd_o    out  serial line, idle high
// -----------------------------------------------------------------------------
module io_uart_tx #(
    parameter int CLKS_PER_BAUD = 868
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       txd_o
);
    import io_pkg::*;

    localparam int              CNT_W    = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BAUD - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             baud_done;

    assign baud_done = (cnt_q == CNT_LAST);

    // NOTE: every assignment in this block is given a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = 1'b1;
        case (state_q)
            TX_IDLE: begin
                if (valid_i) begin
                    shift_d = data_i;
                    cnt_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                txd_d = 1'b0;
                cnt_d = cnt_q + CNT_W'(1);
                if (baud_done) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                txd_d = shift_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (baud_done) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (baud_done) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign ready_o = (state_q == TX_IDLE);
    assign txd_o   = txd_q;

endmodule

// File: rtl/io_periph.sv
// -----------------------------------------------------------------------------
// io_periph
// Memory-mapped IO block on the CPU IO bus: LED register, buffered UART
// transmitter (TX FIFO + io_uart_tx), UART control/status register.
// Optional feature macro: IO_TX_IRQ_EN (TX-done interrupt; irq_o tied low
// and CTRL bit 8 not stored when undefined).
// Ports:
//   clk_i          in   system clock
//   reset_i        in   synchronous, active-high reset
//   IO_memAddr_i   in   byte address; word-address bits [4:2] are one-hot selects
//   IO_memRData_o  out  read data, combinational from address
//   IO_memWData_i  in   write data
//   IO_memWr_i     in   write strobe, one cycle per access
//   leds_o         out  LED register
//   txd_o          out  UART serial output, idle high
//   irq_o          out  TX-done interrupt
// -----------------------------------------------------------------------------
module io_periph #(
    parameter int NUM_LEDS      = 4,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int CLKS_PER_BAUD = 868
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [31:0]         IO_memAddr_i,
    output logic [31:0]         IO_memRData_o,
    input  logic [31:0]         IO_memWData_i,
    input  logic                IO_memWr_i,
    output logic [NUM_LEDS-1:0] leds_o,
    output logic                txd_o,
    output logic                irq_o
);
    import io_pkg::*;

    localparam int               PTR_W    = $clog2(TX_FIFO_DEPTH);
    localparam int               LVL_W    = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(TX_FIFO_DEPTH);

    logic sel_leds, sel_dat, sel_ctrl;
    logic wr_leds, wr_dat, wr_ctrl;

    assign sel_leds = IO_memAddr_i[WORD_ADDR_LSB + IO_LEDS_BIT];
    assign sel_dat  = IO_memAddr_i[WORD_ADDR_LSB + IO_UART_DAT_BIT];
    assign sel_ctrl = IO_memAddr_i[WORD_ADDR_LSB + IO_UART_CTRL_BIT];
    assign wr_leds  = IO_memWr_i & sel_leds;
    assign wr_dat   = IO_memWr_i & sel_dat;
    assign wr_ctrl  = IO_memWr_i & sel_ctrl;

    logic [7:0]          fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                ovf_q, ovf_d;
    logic                fifo_full, fifo_empty, push, pop, tx_ready;
    logic                irq_en;

    assign fifo_full  = (level_q == LVL_FULL);
    assign fifo_empty = (level_q == '0);
    assign pop        = tx_ready & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = wr_dat & (~fifo_full | pop);

    always_comb begin
        leds_d   = leds_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (wr_leds) leds_d   = IO_memWData_i[NUM_LEDS-1:0];
        if (push)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // A dropped byte wins over a simultaneous clear from a multi-select write.
        if (wr_ctrl && IO_memWData_i[CTRL_CLR_OVF_BIT]) ovf_d = 1'b0;
        if (wr_dat && !push)                             ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            leds_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            leds_q   <= leds_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; clearing the pointers
    // and level makes old contents unreachable and keeps this a plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= IO_memWData_i[7:0];
    end

`ifdef IO_TX_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ctrl) irq_en_d = IO_memWData_i[CTRL_IRQ_EN_BIT];
        irq_d = irq_en_q & fifo_empty & tx_ready;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    io_uart_tx #(
        .CLKS_PER_BAUD(CLKS_PER_BAUD)
    ) u_tx (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (~fifo_empty),
        .data_i  (fifo_mem[rd_ptr_q]),
        .ready_o (tx_ready),
        .txd_o   (txd_o)
    );

    // Read mux: UART_CTRL beats LEDS; UART_DAT is write-only.
    always_comb begin
        IO_memRData_o = '0;
        if (sel_ctrl) begin
            IO_memRData_o[ST_FULL_BIT]            = fifo_full;
            IO_memRData_o[ST_EMPTY_BIT]           = fifo_empty;
            IO_memRData_o[ST_ACTIVE_BIT]          = ~tx_ready;
            IO_memRData_o[ST_OVF_BIT]             = ovf_q;
            IO_memRData_o[ST_IRQ_EN_BIT]          = irq_en;
            IO_memRData_o[ST_BUSY_BIT]            = fifo_full;
            IO_memRData_o[ST_LEVEL_LSB +: 8]      = 8'(level_q);
        end else if (sel_leds) begin
            IO_memRData_o[NUM_LEDS-1:0] = leds_q;
        end
    end

    assign leds_o = leds_q;

    // Address bits outside the select field and unused write-data bits.
    logic unused_bits;
    assign unused_bits = ^{IO_memAddr_i[31:WORD_ADDR_LSB+3], IO_memAddr_i[WORD_ADDR_LSB-1:0],
                           IO_memWData_i};

endmodule

// File: tb/tb_io_periph.sv
// -----------------------------------------------------------------------------
// tb_io_periph
// Scoreboard bench for io_periph (NUM_LEDS=4, TX_FIFO_DEPTH=4, CLKS_PER_BAUD=4).
// The driver updates a transaction-level reference model on every clock edge
// and queues expected read data and expected transmitted bytes; independent
// monitors compare bus reads, LEDs, irq_o and decoded UART frames.
// -----------------------------------------------------------------------------
module tb_io_periph;
    localparam int NUM_LEDS = 4;
    localparam int DEPTH    = 4;
    localparam int CPB      = 4;
    localparam int DRAIN_LIMIT = 3000;

    logic                clk = 1'b0;
    logic                reset_i;
    logic [31:0]         addr, wdata, rdata;
    logic                wr;
    logic [NUM_LEDS-1:0] leds;
    logic                txd, irq;

    always #5 clk = ~clk;

    io_periph #(
        .NUM_LEDS      (NUM_LEDS),
        .TX_FIFO_DEPTH (DEPTH),
        .CLKS_PER_BAUD (CPB)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .IO_memAddr_i  (addr),
        .IO_memRData_o (rdata),
        .IO_memWData_i (wdata),
        .IO_memWr_i    (wr),
        .leds_o        (leds),
        .txd_o         (txd),
        .irq_o         (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned        m_fifo[$];    // bytes waiting in the TX FIFO
    int                  m_ser;        // cycles until the serializer is free again
    bit                  m_ovf, m_irq_en, m_irq;
    logic [NUM_LEDS-1:0] m_leds;
    byte unsigned        tx_exp_q[$];  // bytes expected on the serial line
    logic [31:0]         rd_exp_q[$];  // expected bus read data
    bit                  rd_chk, mon_en;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = (m_fifo.size() == DEPTH);
        s[1]   = (m_fifo.size() == 0);
        s[2]   = (m_ser != 0);
        s[3]   = m_ovf;
        s[8]   = m_irq_en;
        s[9]   = (m_fifo.size() == DEPTH);
        s[23:16] = 8'(m_fifo.size());
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] sel);
        if (sel[2]) return m_status();
        if (sel[0]) return {{(32-NUM_LEDS){1'b0}}, m_leds};
        return 32'h0;
    endfunction

    // State change at one clock edge, from the pre-edge model state.
    function automatic void m_edge(input bit rst, input bit w, input logic [2:0] sel,
                                   input logic [31:0] d);
        bit idle, pop, irq_next;
        if (rst) begin
            m_fifo.delete(); tx_exp_q.delete();
            m_ser = 0; m_ovf = 0; m_irq_en = 0; m_irq = 0; m_leds = '0;
            return;
        end
        idle     = (m_ser == 0);
        pop      = idle && (m_fifo.size() > 0);
        irq_next = m_irq_en && (m_fifo.size() == 0) && idle;
        if (pop) begin
            tx_exp_q.push_back(m_fifo.pop_front());
            m_ser = 10 * CPB;
        end else if (m_ser > 0) begin
            m_ser--;
        end
        if (w && sel[0]) m_leds = d[NUM_LEDS-1:0];
        if (w && sel[2]) begin
            if (d[3]) m_ovf = 0;
`ifdef IO_TX_IRQ_EN
            m_irq_en = d[8];
`endif
        end
        if (w && sel[1]) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d[7:0]);
            else                       m_ovf = 1;
        end
`ifdef IO_TX_IRQ_EN
        m_irq = irq_next;
`else
        m_irq = 0;
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit w, input logic [2:0] sel,
                        input logic [31:0] d, input bit do_rd);
        logic [31:0] a;
        @(negedge clk);
        a       = $urandom();
        a[4:2]  = sel;
        reset_i = rst;
        wr      = w;
        addr    = a;
        wdata   = d;
        rd_chk  = do_rd;
        if (do_rd) rd_exp_q.push_back(m_read(sel));
        @(posedge clk);
        m_edge(rst, w, sel, d);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b000, 32'h0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_fifo.size() > 0 || m_ser > 0 || tx_exp_q.size() > 0) && n < DRAIN_LIMIT) begin
            step(1'b0, 1'b0, 3'b000, 32'h0, 1'b0);
            n++;
        end
        check("drain_done", 32'(n < DRAIN_LIMIT), 32'h1);
        idle_steps(3);
    endtask

    // ---------------- read / output monitor ----------------
    initial begin : bus_mon
        forever begin
            @(negedge clk);
            #2;
            if (rd_chk) begin
                if (rd_exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL read_queue: got 0x%08h, expected nothing queued", rdata);
                end else begin
                    check("read_data", rdata, rd_exp_q.pop_front());
                end
            end
            if (mon_en) begin
                check("irq_o", 32'(irq), 32'(m_irq));
                check("leds_o", 32'(leds), 32'(m_leds));
            end
        end
    end

    // ---------------- serial line monitor ----------------
    task automatic ser_wait(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            if (!ab) begin
                @(negedge clk);
                #1;
                if (reset_i) ab = 1'b1;
            end
        end
    endtask

    initial begin : ser_mon
        logic [7:0] b;
        logic       start_b, stop_b;
        bit         ab;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && !reset_i && txd === 1'b0) begin
                ab = 1'b0;
                ser_wait(CPB / 2, ab);
                start_b = txd;
                for (int i = 0; i < 8; i++) begin
                    ser_wait(CPB, ab);
                    b[i] = txd;
                end
                ser_wait(CPB, ab);
                stop_b = txd;
                if (ab) begin
                    while (reset_i) begin
                        @(negedge clk);
                        #1;
                    end
                end else begin
                    check("start_bit", 32'(start_b), 32'h0);
                    check("stop_bit", 32'(stop_b), 32'h1);
                    if (tx_exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL tx_byte: got 0x%02h, expected no frame", b);
                    end else begin
                        check("tx_byte", 32'(b), 32'(tx_exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int n;
        int r;
        logic [2:0] sel;
        reset_i = 1'b1; wr = 1'b0; addr = '0; wdata = '0; rd_chk = 1'b0; mon_en = 1'b0;
        m_ser = 0; m_ovf = 0; m_irq_en = 0; m_irq = 0; m_leds = '0;

        step(1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
        step(1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
        mon_en = 1'b1;
        #1;
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_txd", 32'(txd), 32'h1);
        check("reset_irq", 32'(irq), 32'h0);
        step(1'b0, 1'b0, 3'b100, 32'h0, 1'b1);       // CTRL -> 0x2
        step(1'b0, 1'b0, 3'b001, 32'h0, 1'b1);       // LEDS -> 0

        // LED register
        step(1'b0, 1'b1, 3'b001, 32'h0000000A, 1'b0);
        #1;
        check("leds_write", 32'(leds), 32'hA);
        step(1'b0, 1'b0, 3'b001, 32'h0, 1'b1);
        step(1'b0, 1'b0, 3'b100, 32'h0, 1'b1);

        // First-byte latency: txd falls after the second edge following the write
        step(1'b0, 1'b1, 3'b010, 32'h00000055, 1'b0);
        #1;
        check("latency_edge_n", 32'(txd), 32'h1);
        idle_steps(1);
        #1;
        check("latency_edge_n1", 32'(txd), 32'h1);
        idle_steps(1);
        #1;
        check("latency_edge_n2", 32'(txd), 32'h0);
        drain();
        step(1'b0, 1'b0, 3'b100, 32'h0, 1'b1);       // back to empty, not active

        // Burst of six bytes into a depth-4 FIFO: five accepted, overflow set
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 3'b010, 32'($urandom_range(0, 255)), 1'b0);
        step(1'b0, 1'b0, 3'b100, 32'h0, 1'b1);
        step(1'b0, 1'b0, 3'b100, 32'h0, 1'b1);
        // Clear overflow, rest of status unchanged
        step(1'b0, 1'b1, 3'b100, 32'h00000008, 1'b0);
        step(1'b0, 1'b0, 3'b100, 32'h0, 1'b1);

        // Push landing on the same edge as a pop while full
        n = 0;
        while (m_ser != 0 && n < 1000) begin
            idle_steps(1);
            n++;
        end
        check("pushpop_reach", 32'(m_fifo.size() == DEPTH), 32'h1);
        step(1'b0, 1'b1, 3'b010, 32'($urandom_range(0, 255)), 1'b0);
        step(1'b0, 1'b0, 3'b100, 32'h0, 1'b1);
        drain();

`ifdef IO_TX_IRQ_EN
        step(1'b0, 1'b1, 3'b100, 32'h00000100, 1'b0);
        step(1'b0, 1'b1, 3'b010, 32'h00000041, 1'b0);
        drain();
        #1;
        check("irq_after_frame", 32'(irq), 32'h1);
        step(1'b0, 1'b1, 3'b010, 32'h0000005A, 1'b0);
        idle_steps(1);
        #1;
        check("irq_after_push", 32'(irq), 32'h0);
        drain();
`endif

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: step(1'b0, 1'b1, 3'b010, $urandom(), ($urandom_range(0, 3) == 0));
                4:          step(1'b0, 1'b1, 3'b001, $urandom(), 1'b1);
                5:          step(1'b0, 1'b1, 3'b100, $urandom(), 1'b0);
                6: begin
                    sel = 3'($urandom_range(1, 7));
                    step(1'b0, 1'b1, sel, $urandom(), 1'b1);
                end
                7, 8: begin
                    sel = 3'($urandom_range(0, 7));
                    step(1'b0, 1'b0, sel, 32'h0, 1'b1);
                end
                default: idle_steps($urandom_range(1, 30));
            endcase
        end
        drain();
        step(1'b0, 1'b0, 3'b100, 32'h0, 1'b1);

        // Reset in the middle of a frame with bytes still queued
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 3'b010, 32'($urandom_range(0, 255)), 1'b0);
        idle_steps(15);
        step(1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
        #1;
        check("reset_midframe_txd", 32'(txd), 32'h1);
        step(1'b0, 1'b0, 3'b100, 32'h0, 1'b1);
        drain();
        idle_steps(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
